wb_daq_multi_channel: RTL and testbench

Next-generation DAQ front end that serves NUM_CHANNELS ADC streams with one shared SRAM write port. Each channel packs ADC samples into dw-bit words, or sign-extends one sample per word, and buffers them in a private FIFO. A round-robin burst arbiter drains any FIFO that reaches the programmed threshold to the SRAM writer, tagging each word with its channel number. Sits between the ADC interfaces and the DSP SRAM write engine, in place of per-channel single-stream blocks.

---
 rtl/wb_daq_multi_channel_pkg.sv | 26 ++
 rtl/fifo.sv | 57 +++++
 rtl/wb_daq_pack_lane.sv | 84 ++++++++
 rtl/wb_daq_multi_channel.sv | 163 ++++++++++++++++
 tb/tb_wb_daq_multi_channel.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_daq_multi_channel_pkg.sv
// rtl/wb_daq_multi_channel_pkg.sv - shared types and sizing helpers for the multi-channel DAQ front end
package wb_daq_multi_channel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_PRESENT = 2'd2,
        ST_WAIT    = 2'd3
    } daq_state_e;

    function automatic int samples_per_word(input int word_w, input int sample_w);
        return word_w / sample_w;
    endfunction

    function automatic int chan_idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Zero means "one word"; anything beyond the FIFO could never be reached.
    function automatic int clamp_threshold(input int thr, input int depth);
        if (thr < 1) return 1;
        if (thr > depth) return depth;
        return thr;
    endfunction

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - synchronous FIFO with registered read data and occupancy count
module fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          do_wr, do_rd;

    always_comb begin
        do_wr     = wr_en && (count_q != CW'(DEPTH));
        do_rd     = rd_en && (count_q != '0);
        wptr_d    = do_wr ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = do_rd ? rptr_q + 1'b1 : rptr_q;
        rd_data_d = do_rd ? mem[rptr_q] : rd_data_q;
        count_d   = count_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/wb_daq_pack_lane.sv
// rtl/wb_daq_pack_lane.sv - per-channel sample packer / sign-extender with push strobe and sticky overflow
module wb_daq_pack_lane
    import wb_daq_multi_channel_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 8,
    parameter int dw             = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture,
    input  logic                      channel_enable,
    input  logic                      single_mode,
    input  logic [ADC_DATA_WIDTH-1:0] sample,
    input  logic                      clear_overflow,
    input  logic                      fifo_full,
    output logic                      push,
    output logic [dw-1:0]             push_data,
    output logic                      overflow
);
    localparam int SPW = samples_per_word(dw, ADC_DATA_WIDTH);
    localparam int PCW = (SPW > 1) ? $clog2(SPW) : 1;

    logic [PCW-1:0] cnt_q, cnt_d;
    logic [dw-1:0]  acc_q, acc_d;
    logic [dw-1:0]  word_q, word_d;
    logic           push_q, push_d;
    logic           mode_q, mode_d;
    logic           ovf_q, ovf_d;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        word_d = word_q;
        push_d = 1'b0;
        mode_d = single_mode;
        ovf_d  = ovf_q;
        // A disabled lane or a mode flip invalidates whatever is half-packed.
        if (!channel_enable || (single_mode != mode_q)) begin
            cnt_d = '0;
            acc_d = '0;
        end
        if (capture) begin
            if (single_mode) begin
                word_d = {{(dw-ADC_DATA_WIDTH){sample[ADC_DATA_WIDTH-1]}}, sample};
                push_d = 1'b1;
            end else begin
                acc_d[cnt_d*ADC_DATA_WIDTH +: ADC_DATA_WIDTH] = sample;
                if (cnt_d == PCW'(SPW-1)) begin
                    word_d = acc_d;
                    push_d = 1'b1;
                    cnt_d  = '0;
                    acc_d  = '0;
                end else begin
                    cnt_d = cnt_d + 1'b1;
                end
            end
        end
        if (clear_overflow) ovf_d = 1'b0;
        if (push_q && fifo_full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            word_q <= '0;
            push_q <= 1'b0;
            mode_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            word_q <= word_d;
            push_q <= push_d;
            mode_q <= mode_d;
            ovf_q  <= ovf_d;
        end
    end

    assign push      = push_q;
    assign push_data = word_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/wb_daq_multi_channel.sv
// rtl/wb_daq_multi_channel.sv - multi-channel ADC capture with round-robin burst drain to one SRAM write port
module wb_daq_multi_channel
    import wb_daq_multi_channel_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int ADC_DATA_WIDTH = 8,
    parameter int dw             = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                                     wb_clk,
    input  logic                                     wb_rst,
    input  logic                                     master_enable,
    input  logic [NUM_CHANNELS-1:0]                  channel_enable,
    input  logic [NUM_CHANNELS-1:0]                  single_mode,
    input  logic [NUM_CHANNELS*ADC_DATA_WIDTH-1:0]   adc_data,
    input  logic [NUM_CHANNELS-1:0]                  adc_data_ready,
    input  logic [$clog2(FIFO_DEPTH):0]              fifo_number_samples_terminal,
    input  logic                                     data_done,
    output logic [dw-1:0]                            sram_data_out,
    output logic [chan_idx_width(NUM_CHANNELS)-1:0]  sram_channel,
    output logic                                     sram_start,
    output logic                                     burst_active,
    output logic [NUM_CHANNELS-1:0]                  fifo_empty,
    output logic [NUM_CHANNELS-1:0]                  overflow,
    input  logic [NUM_CHANNELS-1:0]                  clear_overflow
);
    localparam int CHW = chan_idx_width(NUM_CHANNELS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CHANNELS-1:0] push, full, pop, eligible;
    logic [dw-1:0]           push_data [NUM_CHANNELS];
    logic [dw-1:0]           rd_data   [NUM_CHANNELS];
    logic [CW-1:0]           count     [NUM_CHANNELS];
    logic [CW-1:0]           thr;

    daq_state_e     state_q, state_d;
    logic [CHW-1:0] grant_q, grant_d, ptr_q, ptr_d, pick;
    logic [CW-1:0]  remaining_q, remaining_d;
    logic           burst_q, burst_d, start_q, start_d, found;
    logic [dw-1:0]  data_q, data_d;
    logic [CHW-1:0] chan_q, chan_d;
    int             cand;

    assign thr = CW'(clamp_threshold(int'(fifo_number_samples_terminal), FIFO_DEPTH));

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        wb_daq_pack_lane #(
            .ADC_DATA_WIDTH(ADC_DATA_WIDTH),
            .dw            (dw)
        ) u_lane (
            .clk           (wb_clk),
            .rst           (wb_rst),
            .capture       (master_enable & channel_enable[i] & adc_data_ready[i]),
            .channel_enable(channel_enable[i]),
            .single_mode   (single_mode[i]),
            .sample        (adc_data[i*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
            .clear_overflow(clear_overflow[i]),
            .fifo_full     (full[i]),
            .push          (push[i]),
            .push_data     (push_data[i]),
            .overflow      (overflow[i])
        );

        fifo #(
            .DW   (dw),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk    (wb_clk),
            .rst    (wb_rst),
            .wr_en  (push[i]),
            .wr_data(push_data[i]),
            .rd_en  (pop[i]),
            .rd_data(rd_data[i]),
            .full   (full[i]),
            .empty  (fifo_empty[i]),
            .count  (count[i])
        );

        assign pop[i]      = (state_q == ST_POP) && (grant_q == CHW'(i));
        assign eligible[i] = (count[i] >= thr);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        start_d     = 1'b0;
        data_d      = data_q;
        chan_d      = chan_q;
        found       = 1'b0;
        pick        = '0;
        cand        = 0;
        // Search starts at the pointer so the last-served channel goes to the back.
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
            if (!found && eligible[CHW'(cand)]) begin
                found = 1'b1;
                pick  = CHW'(cand);
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (master_enable && found) begin
                    grant_d     = pick;
                    remaining_d = thr;
                    burst_d     = 1'b1;
                    state_d     = ST_POP;
                end
            end
            ST_POP: state_d = ST_PRESENT;
            ST_PRESENT: begin
                data_d  = rd_data[grant_q];
                chan_d  = grant_q;
                start_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_done) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CW'(1)) begin
                        ptr_d   = (grant_q == CHW'(NUM_CHANNELS-1)) ? '0 : grant_q + 1'b1;
                        burst_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_POP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            remaining_q <= '0;
            burst_q     <= 1'b0;
            start_q     <= 1'b0;
            data_q      <= '0;
            chan_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            start_q     <= start_d;
            data_q      <= data_d;
            chan_q      <= chan_d;
        end
    end

    assign sram_data_out = data_q;
    assign sram_channel  = chan_q;
    assign sram_start    = start_q;
    assign burst_active  = burst_q;

endmodule

// File: tb/tb_wb_daq_multi_channel.sv
// tb/tb_wb_daq_multi_channel.sv - self-checking bench for wb_daq_multi_channel against a queue-based reference model
module tb_wb_daq_multi_channel;
    localparam int N     = 4;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, master_enable, data_done;
    logic [N-1:0]    channel_enable, single_mode, adc_data_ready, clear_overflow;
    logic [N*AW-1:0] adc_data;
    logic [4:0]      thr;
    logic [DW-1:0]   sram_data_out;
    logic [1:0]      sram_channel;
    logic            sram_start, burst_active;
    logic [N-1:0]    fifo_empty, overflow;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] fq   [N][$];
    logic [AW-1:0] part [N][$];
    logic [N-1:0]  ovf_m, drop_now;
    logic [DW-1:0] obs_data [$];
    int            obs_ch   [$];

    wb_daq_multi_channel #(
        .NUM_CHANNELS(N), .ADC_DATA_WIDTH(AW), .dw(DW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .wb_clk(clk), .wb_rst(rst), .master_enable(master_enable),
        .channel_enable(channel_enable), .single_mode(single_mode),
        .adc_data(adc_data), .adc_data_ready(adc_data_ready),
        .fifo_number_samples_terminal(thr), .data_done(data_done),
        .sram_data_out(sram_data_out), .sram_channel(sram_channel),
        .sram_start(sram_start), .burst_active(burst_active),
        .fifo_empty(fifo_empty), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always @(negedge clk) begin
        if (sram_start) begin
            obs_data.push_back(sram_data_out);
            obs_ch.push_back(int'(sram_channel));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input int c, input logic [DW-1:0] w);
        if (fq[c].size() < DEPTH) fq[c].push_back(w);
        else begin
            ovf_m[c]    = 1'b1;
            drop_now[c] = 1'b1;
        end
    endtask

    task automatic model_sample(input int c, input logic [AW-1:0] s);
        logic [DW-1:0] w;
        if (single_mode[c]) begin
            w = {{(DW-AW){s[AW-1]}}, s};
            push_model(c, w);
        end else begin
            part[c].push_back(s);
            if (part[c].size() == 4) begin
                w = {part[c][3], part[c][2], part[c][1], part[c][0]};
                part[c].delete();
                push_model(c, w);
            end
        end
    endtask

    task automatic send(input logic [N-1:0] mask, input logic [N*AW-1:0] vals, input logic [N-1:0] clr);
        @(negedge clk);
        drop_now       = '0;
        adc_data       = vals;
        adc_data_ready = mask;
        for (int c = 0; c < N; c++)
            if (mask[c] && master_enable && channel_enable[c]) model_sample(c, vals[c*AW +: AW]);
        for (int c = 0; c < N; c++)
            if (clr[c] && !drop_now[c]) ovf_m[c] = 1'b0;
        @(negedge clk);
        adc_data_ready = '0;
        clear_overflow = clr;
        @(negedge clk);
        clear_overflow = '0;
    endtask

    task automatic send_one(input int c, input logic [AW-1:0] s);
        logic [N*AW-1:0] v;
        v = '0;
        v[c*AW +: AW] = s;
        send(N'(1) << c, v, '0);
    endtask

    task automatic set_modes(input logic [N-1:0] en, input logic [N-1:0] sm);
        @(negedge clk);
        for (int c = 0; c < N; c++)
            if (!en[c] || (sm[c] != single_mode[c])) part[c].delete();
        channel_enable = en;
        single_mode    = sm;
    endtask

    task automatic wait_start(input int exp_ch);
        int n;
        int ch;
        logic [DW-1:0] w, exp_w;
        n = 0;
        while (obs_ch.size() == 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("start_seen", obs_ch.size() != 0, 1);
        if (obs_ch.size() == 0) return;
        ch = obs_ch.pop_front();
        w  = obs_data.pop_front();
        if (exp_ch >= 0) check("sram_channel", ch, exp_ch);
        if (fq[ch].size() == 0) check("word_expected", 0, 1);
        else begin
            exp_w = fq[ch].pop_front();
            check("sram_data_out", w, exp_w);
        end
        check("burst_active_in_wait", burst_active, 1);
    endtask

    task automatic done_pulse();
        data_done = 1'b1;
        @(negedge clk);
        data_done = 1'b0;
        check("start_single_cycle", sram_start, 0);
    endtask

    task automatic serve(input int ch, input int n);
        repeat (n) begin
            wait_start(ch);
            done_pulse();
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"}, sram_data_out, 0);
        check({tag, "_chan"}, sram_channel, 0);
        check({tag, "_start"}, sram_start, 0);
        check({tag, "_burst"}, burst_active, 0);
        check({tag, "_empty"}, fifo_empty, 4'hF);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    function automatic int model_words();
        int t = 0;
        for (int c = 0; c < N; c++) t += fq[c].size();
        return t;
    endfunction

    initial begin
        logic [N*AW-1:0] rv;
        int guard;
        rst = 1'b1; master_enable = 1'b0; data_done = 1'b0; thr = 5'd2;
        channel_enable = '0; single_mode = '0; adc_data_ready = '0;
        clear_overflow = '0; adc_data = '0; ovf_m = '0; drop_now = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        // Packed burst on channel 1, threshold 2.
        master_enable = 1'b1;
        set_modes(4'hF, 4'h0);
        for (int s = 1; s <= 8; s++) send_one(1, AW'(s));
        wait_start(1);
        check("pk_word0", sram_data_out, 32'h04030201);
        done_pulse();
        wait_start(1);
        check("pk_word1", sram_data_out, 32'h08070605);
        done_pulse();
        check("pk_burst_end", burst_active, 0);
        repeat (6) @(negedge clk);
        check("pk_no_extra_start", obs_ch.size(), 0);
        check("pk_empty", fifo_empty, 4'hF);

        // Single mode on channel 2; threshold 0 behaves as 1.
        thr = 5'd0;
        set_modes(4'hF, 4'b0100);
        send_one(2, 8'h80);
        wait_start(2);
        check("sx_neg", sram_data_out, 32'hFFFFFF80);
        done_pulse();
        send_one(2, 8'h7F);
        wait_start(2);
        check("sx_pos", sram_data_out, 32'h0000007F);
        done_pulse();

        // Reset while a burst sits in WAIT with one more word queued.
        send_one(2, 8'h55);
        send_one(2, 8'h66);
        wait_start(2);
        #2 rst = 1'b1;
        #1 check_reset("async");
        for (int c = 0; c < N; c++) begin
            fq[c].delete();
            part[c].delete();
        end
        ovf_m = '0;
        @(negedge clk);
        rst = 1'b0;
        obs_ch.delete();
        obs_data.delete();
        repeat (10) @(negedge clk);
        check("post_rst_burst", burst_active, 0);
        check("post_rst_starts", obs_ch.size(), 0);

        // Round robin: 0 and 3 together from pointer 0, then refilled 0 waits behind 3.
        set_modes(4'hF, 4'hF);
        send(4'b1001, $urandom, '0);
        wait_start(0);
        send(4'b0001, $urandom, '0);
        done_pulse();
        serve(3, 1);
        serve(0, 1);
        check("rr_idle", burst_active, 0);

        // Overflow on channel 0 with a clamped threshold of 16.
        thr = 5'd31;
        for (int i = 0; i < DEPTH; i++) send_one(0, AW'($urandom));
        wait_start(0);
        send_one(0, AW'($urandom));
        check("ovf_not_yet", overflow, ovf_m);
        send_one(0, AW'($urandom));
        check("ovf_set", overflow[0], 1);
        check("ovf_model", overflow, ovf_m);
        send('0, '0, 4'b0001);
        check("ovf_clear", overflow, ovf_m);
        send(4'b0001, $urandom, 4'b0001);
        check("ovf_set_wins", overflow[0], 1);
        check("ovf_model2", overflow, ovf_m);
        done_pulse();
        serve(0, DEPTH-1);
        check("ovf_burst_end", burst_active, 0);
        thr = 5'd1;
        serve(0, 1);
        send('0, '0, 4'b0001);
        check("ovf_final_clear", overflow, 0);

        // Enable drop discards a partial packed word.
        set_modes(4'hF, 4'h0);
        for (int i = 0; i < 3; i++) send_one(1, AW'($urandom));
        set_modes(4'b1101, 4'h0);
        set_modes(4'hF, 4'h0);
        for (int i = 0; i < 4; i++) send_one(1, AW'($urandom));
        wait_start(1);
        done_pulse();
        repeat (6) @(negedge clk);
        check("en_drop_single_word", obs_ch.size(), 0);

        // Randomised traffic on all channels, drained in whatever order the arbiter picks.
        set_modes(4'hF, N'($urandom));
        for (int i = 0; i < 14; i++) begin
            rv = $urandom;
            send(N'($urandom), rv, '0);
        end
        guard = 0;
        while (model_words() > 0 && guard < 80) begin
            wait_start(-1);
            done_pulse();
            guard++;
        end
        repeat (8) @(negedge clk);
        check("rnd_drained", fifo_empty, 4'hF);
        check("rnd_no_extra", obs_ch.size(), 0);
        check("rnd_ovf", overflow, ovf_m);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
